// File: rtl/bitblaster_program_feeder.sv
// bitblaster_program_feeder
// Autonomous instruction source for the Bitblaster 10-bit processor. Holds a
// small program memory, presents each word on DATA_OUT (plus the operand word
// for ld), pulses STEP until the processor reports DONE_IN, then advances.
// A run stops on a halt word (HALTED) or on a protocol fault (FAULT).
//
// Optional feature macro: FEEDER_RETIRE_COUNT_EN
//   defined   -> RETIRED is a 16-bit wrapping count of retired instructions
//   undefined -> RETIRED is tied to zero
//
// Ports:
//   CLK_50MHz   in  clock, rising edge
//   CLR         in  asynchronous active-high reset
//   GO          in  start request (sampled in IDLE/STOP)
//   PROG_WE     in  program memory write enable (ignored while BUSY)
//   PROG_ADDR   in  program memory write address
//   PROG_WDATA  in  program memory write data
//   DONE_IN     in  processor done flag
//   TIME_IN     in  processor timestep counter
//   DATA_OUT    out word presented to the processor data input
//   STEP        out one-cycle step strobe
//   PC_OUT      out address of the presented word
//   BUSY        out high while a run is in progress
//   HALTED      out sticky, halt word reached
//   FAULT       out sticky, protocol fault
//   RETIRED     out retired instruction count
module bitblaster_program_feeder #(
  parameter int ADDR_W     = 6,
  parameter int SETTLE_CYC = 4,
  parameter int MAX_STEPS  = 4
) (
  input  logic              CLK_50MHz,
  input  logic              CLR,
  input  logic              GO,
  input  logic              PROG_WE,
  input  logic [ADDR_W-1:0] PROG_ADDR,
  input  logic [9:0]        PROG_WDATA,
  input  logic              DONE_IN,
  input  logic [1:0]        TIME_IN,
  output logic [9:0]        DATA_OUT,
  output logic              STEP,
  output logic [ADDR_W-1:0] PC_OUT,
  output logic              BUSY,
  output logic              HALTED,
  output logic              FAULT,
  output logic [15:0]       RETIRED
);

  localparam int         DEPTH       = 1 << ADDR_W;
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [7:0] STEP_LIMIT  = 8'(MAX_STEPS);

  typedef enum logic [2:0] {
    S_IDLE, S_PRESENT, S_STROBE, S_OPND, S_SETTLE, S_CHECK, S_DONE_ST, S_STOP
  } state_t;

  state_t            state_q;
  logic [9:0]        data_q;
  logic              step_q;
  logic [ADDR_W-1:0] pc_q;
  logic              busy_q;
  logic              halted_q;
  logic              fault_q;
  logic [7:0]        settle_cnt_q;
  logic [7:0]        step_cnt_q;

  logic [9:0]        mem_q [DEPTH];

  logic [ADDR_W-1:0] pc_next_d;
  logic [9:0]        go_word_d;
  logic              go_start_d;
  logic              is_halt_d;
  logic              is_ld_d;

  // Program memory: writes only while idle, so a run never sees a changing word.
  always_ff @(posedge CLK_50MHz) begin
    if (PROG_WE && !busy_q) begin
      mem_q[PROG_ADDR] <= PROG_WDATA;
    end
  end

  assign pc_next_d  = pc_q + ADDR_W'(1);   // wraps naturally at 2^ADDR_W
  assign go_start_d = GO && (state_q == S_IDLE || state_q == S_STOP);
  // A write to address 0 in the GO cycle is forwarded so the run sees it.
  assign go_word_d  = (PROG_WE && (PROG_ADDR == '0)) ? PROG_WDATA : mem_q[0];
  assign is_halt_d  = (data_q[9:8] == 2'b01);
  assign is_ld_d    = (data_q[9:8] == 2'b00) && (data_q[3:0] == 4'b0000);

  always_ff @(posedge CLK_50MHz or posedge CLR) begin
    if (CLR) begin
      state_q      <= S_IDLE;
      data_q       <= '0;
      step_q       <= 1'b0;
      pc_q         <= '0;
      busy_q       <= 1'b0;
      halted_q     <= 1'b0;
      fault_q      <= 1'b0;
      settle_cnt_q <= '0;
      step_cnt_q   <= '0;
    end else begin
      step_q <= 1'b0;
      case (state_q)
        S_IDLE, S_STOP: begin
          if (go_start_d) begin
            pc_q         <= '0;
            halted_q     <= 1'b0;
            fault_q      <= 1'b0;
            data_q       <= go_word_d;
            settle_cnt_q <= '0;
            busy_q       <= 1'b1;
            state_q      <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          if (is_halt_d) begin
            halted_q <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= S_STOP;
          end else if (TIME_IN != 2'b00) begin
            // Processor is mid-instruction when it should be at T0.
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_STOP;
          end else if (settle_cnt_q == SETTLE_LAST) begin
            step_q  <= 1'b1;   // high during STROBE
            state_q <= S_STROBE;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        S_STROBE: begin
          step_cnt_q   <= 8'd1;
          settle_cnt_q <= '0;
          if (is_ld_d) begin
            // Operand fetch: registered read lands as OPND is entered.
            pc_q    <= pc_next_d;
            data_q  <= mem_q[pc_next_d];
            state_q <= S_OPND;
          end else begin
            state_q <= S_SETTLE;
          end
        end
        S_OPND, S_SETTLE: begin
          if (settle_cnt_q == SETTLE_LAST) begin
            state_q <= S_CHECK;
          end else begin
            settle_cnt_q <= settle_cnt_q + 8'd1;
          end
        end
        S_CHECK: begin
          settle_cnt_q <= '0;
          if (DONE_IN) begin
            step_q  <= 1'b1;   // completing step, high during DONE_ST
            state_q <= S_DONE_ST;
          end else if (step_cnt_q == STEP_LIMIT) begin
            fault_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_STOP;
          end else begin
            step_q     <= 1'b1;
            step_cnt_q <= step_cnt_q + 8'd1;
            state_q    <= S_SETTLE;
          end
        end
        S_DONE_ST: begin
          pc_q         <= pc_next_d;
          data_q       <= mem_q[pc_next_d];
          settle_cnt_q <= '0;
          state_q      <= S_PRESENT;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef FEEDER_RETIRE_COUNT_EN
  logic [15:0] retired_q;
  always_ff @(posedge CLK_50MHz or posedge CLR) begin
    if (CLR) begin
      retired_q <= '0;
    end else if (go_start_d) begin
      retired_q <= '0;
    end else if (state_q == S_DONE_ST) begin
      retired_q <= retired_q + 16'd1;
    end
  end
  assign RETIRED = retired_q;
`else
  assign RETIRED = 16'd0;
`endif

  assign DATA_OUT = data_q;
  assign STEP     = step_q;
  assign PC_OUT   = pc_q;
  assign BUSY     = busy_q;
  assign HALTED   = halted_q;
  assign FAULT    = fault_q;

endmodule
